// File: rtl/ahb_uvc_slv_pkg.sv
// Shared types and widths for the AHB-Lite slave memory.
package ahb_uvc_slv_pkg;

  localparam int HTRANS_WIDTH = 2;
  localparam int HSIZE_WIDTH  = 3;
  localparam int HBURST_WIDTH = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DATA,
    ERR1,
    ERR2
  } state_e;

endpackage

// File: rtl/ahb_uvc_slv_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) for random wait states.
// Only built when AHB_UVC_SLV_RAND_WAIT_EN is defined.
`ifdef AHB_UVC_SLV_RAND_WAIT_EN
module ahb_uvc_slv_lfsr (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign lfsr_o = lfsr_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)  lfsr_q <= 16'h0001;
    else if (en_i) lfsr_q <= lfsr_d;
  end

endmodule
`endif

// File: rtl/ahb_uvc_slave_mem.sv
// AHB-Lite slave memory with wait states, two-cycle ERROR and write->read forwarding.
// Define AHB_UVC_SLV_RAND_WAIT_EN for LFSR-randomised wait counts.
module ahb_uvc_slave_mem
  import ahb_uvc_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    Hsel,
  input  logic [ADDR_WIDTH-1:0]   Haddr,
  input  logic [HTRANS_WIDTH-1:0] Htrans,
  input  logic                    Hwrite,
  input  logic [HSIZE_WIDTH-1:0]  Hsize,
  input  logic [HBURST_WIDTH-1:0] Hburst,
  input  logic [DATA_WIDTH-1:0]   Hwdata,
  input  logic                    Hready,
  output logic                    Hreadyout,
  output logic                    Hresp,
  output logic [DATA_WIDTH-1:0]   Hrdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BL = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [HSIZE_WIDTH-1:0] MAX_SIZE = HSIZE_WIDTH'(BL);

  logic [NB-1:0][7:0] mem [MEM_DEPTH];

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d, wait_cnt;
  logic [BL+IW-1:0]        addr_q;
  logic                    write_q;
  logic [HSIZE_WIDTH-1:0]  size_q;
  logic [DATA_WIDTH-1:0]   hrdata_q, rd_data;
  logic                    accept, err, rd_go, wr_go, fwd;
  logic [IW-1:0]           rd_idx, wr_idx;
  logic [NB-1:0]           be;
  logic                    unused_ok;

  assign unused_ok = ^Hburst;

  assign accept = (state_q == IDLE || state_q == DATA || state_q == ERR2) &&
                  Hsel && Hready &&
                  (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);

  assign err = (Hsize > MAX_SIZE) ||
               (|(Haddr & ((ADDR_WIDTH'(1) << Hsize) - ADDR_WIDTH'(1)))) ||
               ((Haddr >> BL) >= ADDR_WIDTH'(MEM_DEPTH));

`ifdef AHB_UVC_SLV_RAND_WAIT_EN
  logic [15:0] lfsr;
  ahb_uvc_slv_lfsr u_lfsr (
    .hclk    (hclk),
    .hresetn (hresetn),
    .en_i    (accept),
    .lfsr_o  (lfsr)
  );
  assign wait_cnt = 4'(lfsr % 16'(WAIT_STATES + 1));
`else
  assign wait_cnt = 4'(WAIT_STATES);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DATA, ERR2: begin
        if (!accept)           state_d = IDLE;
        else if (err)          state_d = ERR1;
        else if (wait_cnt != 0) begin
          state_d = WAIT;
          cnt_d   = wait_cnt;
        end else               state_d = DATA;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DATA;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Read data is captured on the edge that enters DATA; a write committing on
  // that same edge is merged in so back-to-back reads see the new value.
  assign rd_idx = (state_q == WAIT) ? addr_q[BL +: IW] : Haddr[BL +: IW];
  assign wr_idx = addr_q[BL +: IW];
  assign rd_go  = (state_d == DATA) && ((state_q == WAIT) ? !write_q : !Hwrite);
  assign wr_go  = hresetn && (state_q == DATA) && write_q;
  assign fwd    = wr_go && (wr_idx == rd_idx);
  assign be     = NB'(((32'd1 << (32'd1 << size_q)) - 32'd1) << addr_q[BL-1:0]);

  always_comb begin
    rd_data = '0;
    for (int l = 0; l < NB; l++)
      rd_data[l*8 +: 8] = (fwd && be[l]) ? Hwdata[l*8 +: 8] : mem[rd_idx][l];
  end

  always_ff @(posedge hclk) begin
    if (wr_go)
      for (int l = 0; l < NB; l++)
        if (be[l]) mem[wr_idx][l] <= Hwdata[l*8 +: 8];
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= Haddr[BL+IW-1:0];
        write_q <= Hwrite;
        size_q  <= Hsize;
      end
      if (rd_go) hrdata_q <= rd_data;
    end
  end

  assign Hreadyout = !(state_q == WAIT || state_q == ERR1);
  assign Hresp     = (state_q == ERR1 || state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign Hrdata    = hrdata_q;

endmodule
